// File: rtl/gamma_lut_stream.sv
// Streaming multi-channel gamma LUT with double-buffered per-channel tables and a 2-stage pipeline.
// Optional shadow-bank readback port enabled by defining GAMMA_READBACK_EN.
module gamma_lut_stream #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned OUT_W    = 8,
  parameter int unsigned CHANNELS = 3,
  localparam int unsigned ChW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_n,
  input  logic                         enable_i,
  input  logic                         s_valid_i,
  output logic                         s_ready_o,
  input  logic [CHANNELS*DATA_W-1:0]   s_data_i,
  input  logic                         s_sof_i,
  output logic                         m_valid_o,
  input  logic                         m_ready_i,
  output logic [CHANNELS*OUT_W-1:0]    m_data_o,
  output logic                         m_sof_o,
  input  logic                         cfg_we_i,
  input  logic [ChW-1:0]               cfg_ch_i,
  input  logic [DATA_W-1:0]            cfg_addr_i,
  input  logic [OUT_W-1:0]             cfg_wdata_i,
  input  logic                         cfg_swap_i,
`ifdef GAMMA_READBACK_EN
  input  logic                         cfg_re_i,
  output logic [OUT_W-1:0]             cfg_rdata_o,
  output logic                         cfg_rvalid_o,
`endif
  output logic                         cfg_swap_pend_o,
  output logic                         active_bank_o
);

  localparam int unsigned Depth = 2 ** DATA_W;
  // Pass-through keeps the MSBs when narrowing, zero-extends when widening.
  localparam int unsigned Shift = (DATA_W > OUT_W) ? DATA_W - OUT_W : 0;

  logic ce, accept, swap_apply;
  logic bank_q, bank_d, pend_q, pend_d;

  logic                       s1_valid_q, s1_sof_q, s1_en_q, s1_bank_q;
  logic [CHANNELS*DATA_W-1:0] s1_data_q;

  logic                      m_valid_q, m_sof_q, m_en_q;
  logic [CHANNELS*OUT_W-1:0] pt_q, pt_d;

  always_comb begin
    ce         = !m_valid_q || m_ready_i;
    accept     = s_valid_i && ce;
    swap_apply = accept && s_sof_i && pend_q;
    bank_d     = bank_q ^ swap_apply;
    pend_d     = swap_apply ? cfg_swap_i : (pend_q || cfg_swap_i);
    pt_d       = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      pt_d[c*OUT_W +: OUT_W] = OUT_W'(s1_data_q[c*DATA_W +: DATA_W] >> Shift);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      bank_q     <= 1'b0;
      pend_q     <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_sof_q   <= 1'b0;
      s1_en_q    <= 1'b0;
      s1_bank_q  <= 1'b0;
      s1_data_q  <= '0;
      m_valid_q  <= 1'b0;
      m_sof_q    <= 1'b0;
      m_en_q     <= 1'b0;
      pt_q       <= '0;
    end else begin
      bank_q <= bank_d;
      pend_q <= pend_d;
      if (ce) begin
        s1_valid_q <= s_valid_i;
        m_valid_q  <= s1_valid_q;
        if (accept) begin
          s1_data_q <= s_data_i;
          s1_sof_q  <= s_sof_i;
          s1_en_q   <= enable_i;
          s1_bank_q <= bank_d;
        end
        if (s1_valid_q) begin
          m_sof_q <= s1_sof_q;
          m_en_q  <= s1_en_q;
          pt_q    <= pt_d;
        end
      end
    end
  end

`ifdef GAMMA_READBACK_EN
  logic                      rb_pend_q, rb_bank_q, rvalid_q;
  logic [ChW-1:0]            rb_ch_q;
  logic [DATA_W-1:0]         rb_addr_q;
  logic [OUT_W-1:0]          rdata_q, rb_sel;
  logic [CHANNELS*OUT_W-1:0] rb_words;
`endif

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [OUT_W-1:0] ram_q [2][Depth];
    logic [OUT_W-1:0] rd_q;

    // Table storage is never reset; cfg writes always target the shadow bank.
    always_ff @(posedge clk_i) begin
      if (cfg_we_i && (cfg_ch_i == ChW'(c))) begin
        ram_q[~bank_q][cfg_addr_i] <= cfg_wdata_i;
      end
      if (ce && s1_valid_q) begin
        rd_q <= ram_q[s1_bank_q][s1_data_q[c*DATA_W +: DATA_W]];
      end
    end

    assign m_data_o[c*OUT_W +: OUT_W] = m_en_q ? rd_q : pt_q[c*OUT_W +: OUT_W];

`ifdef GAMMA_READBACK_EN
    assign rb_words[c*OUT_W +: OUT_W] = ram_q[rb_bank_q][rb_addr_q];
`endif
  end

`ifdef GAMMA_READBACK_EN
  always_comb begin
    rb_sel = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (32'(rb_ch_q) == c) rb_sel = rb_words[c*OUT_W +: OUT_W];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      rb_pend_q <= 1'b0;
      rb_bank_q <= 1'b0;
      rb_ch_q   <= '0;
      rb_addr_q <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      rb_pend_q <= cfg_re_i;
      rvalid_q  <= rb_pend_q;
      if (cfg_re_i) begin
        rb_bank_q <= ~bank_q;
        rb_ch_q   <= cfg_ch_i;
        rb_addr_q <= cfg_addr_i;
      end
      if (rb_pend_q) rdata_q <= rb_sel;
    end
  end

  assign cfg_rdata_o  = rdata_q;
  assign cfg_rvalid_o = rvalid_q;
`else
  // Shadow bank is write-only here: no second read port on the tables.
`endif

  assign s_ready_o       = ce;
  assign m_valid_o       = m_valid_q;
  assign m_sof_o         = m_sof_q;
  assign cfg_swap_pend_o = pend_q;
  assign active_bank_o   = bank_q;

endmodule

// File: tb/tb_gamma_lut_stream.sv
// Randomized bench for gamma_lut_stream (DATA_W=8, OUT_W=10, 3 channels) against a table/queue model.
// Readback checks are included when GAMMA_READBACK_EN is defined.
module tb_gamma_lut_stream;

  logic        clk = 1'b0;
  logic        rst_n, enable, s_valid, s_ready, s_sof, m_valid, m_ready, m_sof;
  logic [23:0] s_data;
  logic [29:0] m_data;
  logic        cfg_we, cfg_swap, cfg_swap_pend, active_bank;
  logic [1:0]  cfg_ch;
  logic [7:0]  cfg_addr;
  logic [9:0]  cfg_wdata;
`ifdef GAMMA_READBACK_EN
  logic        cfg_re, cfg_rvalid;
  logic [9:0]  cfg_rdata;
`endif

  gamma_lut_stream #(.DATA_W(8), .OUT_W(10), .CHANNELS(3)) dut (
    .clk_i(clk), .rst_n(rst_n), .enable_i(enable),
    .s_valid_i(s_valid), .s_ready_o(s_ready), .s_data_i(s_data), .s_sof_i(s_sof),
    .m_valid_o(m_valid), .m_ready_i(m_ready), .m_data_o(m_data), .m_sof_o(m_sof),
    .cfg_we_i(cfg_we), .cfg_ch_i(cfg_ch), .cfg_addr_i(cfg_addr), .cfg_wdata_i(cfg_wdata),
    .cfg_swap_i(cfg_swap),
`ifdef GAMMA_READBACK_EN
    .cfg_re_i(cfg_re), .cfg_rdata_o(cfg_rdata), .cfg_rvalid_o(cfg_rvalid),
`endif
    .cfg_swap_pend_o(cfg_swap_pend), .active_bank_o(active_bank)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [29:0] d;
    logic        sof;
    int          acc;
    int          in0;
    bit          en;
    bit          pin;
    bit          strict;
  } exp_t;

  int   checks = 0, failures = 0;
  int   tbl [3][2][256];
  bit   m_bank, m_pend, ap;
  exp_t q[$];
  exp_t mon_e;
  int   cyc = 0;
  bit   prev_stall;
  logic [29:0] prev_data;
  logic prev_sof;
  bit   strict = 0, pin_gamma = 0, rand_ready = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int gamma8(input int x);
    real r;
    r = 255.0 * ((real'(x) / 255.0) ** 2.2);
    return int'($floor(r));
  endfunction

  // Model and compare: expectations are fixed at acceptance from the model tables and bank.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      q.delete();
      m_bank     = 1'b0;
      m_pend     = 1'b0;
      prev_stall = 1'b0;
    end else begin
      chk("active_bank", 32'(active_bank), 32'(m_bank));
      chk("swap_pend", 32'(cfg_swap_pend), 32'(m_pend));
      if (prev_stall) begin
        chk("stall_valid", 32'(m_valid), 1);
        chk("stall_data", 32'(m_data), 32'(prev_data));
        chk("stall_sof", 32'(m_sof), 32'(prev_sof));
      end
      if (m_valid && m_ready) begin
        chk("beat_expected", 32'(q.size() > 0), 1);
        if (q.size() > 0) begin
          mon_e = q.pop_front();
          chk("m_data", 32'(m_data), 32'(mon_e.d));
          chk("m_sof", 32'(m_sof), 32'(mon_e.sof));
          if (mon_e.strict) chk("latency", 32'(cyc - mon_e.acc), 2);
          if (mon_e.pin && mon_e.en && mon_e.in0 == 128) chk("gamma128", 32'(m_data[9:0]), 55);
          if (mon_e.pin && mon_e.en && mon_e.in0 == 255) chk("gamma255", 32'(m_data[9:0]), 255);
          if (!mon_e.en && mon_e.in0 == 200) chk("pass200", 32'(m_data[9:0]), 200);
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_sof   = m_sof;
      if (strict && s_valid) chk("full_rate_ready", 32'(s_ready), 1);
      if (cfg_we && cfg_ch < 3) tbl[cfg_ch][~m_bank][cfg_addr] = int'(cfg_wdata);
      if (s_valid && s_ready) begin
        ap = s_sof && m_pend;
        if (ap) begin
          m_bank = !m_bank;
          m_pend = cfg_swap;
        end else if (cfg_swap) begin
          m_pend = 1'b1;
        end
        mon_e.d = '0;
        for (int c = 0; c < 3; c++) begin
          int x;
          x = int'(s_data[c*8 +: 8]);
          mon_e.d[c*10 +: 10] = enable ? 10'(tbl[c][m_bank][x]) : 10'(x);
        end
        mon_e.sof    = s_sof;
        mon_e.acc    = cyc;
        mon_e.in0    = int'(s_data[7:0]);
        mon_e.en     = enable;
        mon_e.pin    = pin_gamma;
        mon_e.strict = strict;
        q.push_back(mon_e);
      end else if (cfg_swap) begin
        m_pend = 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int ch, input int a, input int d);
    cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_addr = 8'(a); cfg_wdata = 10'(d);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic send(input logic [23:0] d, input bit sof, input bit sw);
    bit acc;
    int n;
    acc = 1'b0; n = 0;
    s_valid = 1'b1; s_data = d; s_sof = sof; cfg_swap = sw;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = s_ready;
      tick();
      cfg_swap = 1'b0;
      n++;
    end
    chk("send_accepted", 32'(acc), 1);
    s_valid = 1'b0; s_sof = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 500) begin
      tick();
      n++;
    end
    chk("drain_empty", 32'(q.size()), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; enable = 1'b1; s_valid = 1'b0; s_data = '0; s_sof = 1'b0; m_ready = 1'b1;
    cfg_we = 1'b0; cfg_ch = '0; cfg_addr = '0; cfg_wdata = '0; cfg_swap = 1'b0;
`ifdef GAMMA_READBACK_EN
    cfg_re = 1'b0;
`endif
    repeat (3) tick();
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_m_data", 32'(m_data), 0);
    chk("rst_m_sof", 32'(m_sof), 0);
    chk("rst_pend", 32'(cfg_swap_pend), 0);
    chk("rst_bank", 32'(active_bank), 0);
    chk("rst_s_ready", 32'(s_ready), 1);
    rst_n = 1'b1;
    tick();
    chk("model_g128", 32'(gamma8(128)), 55);
    chk("model_g255", 32'(gamma8(255)), 255);

    // Identity into shadow bank 1, then reset with a swap pending and beats in flight.
    for (int c = 0; c < 3; c++) for (int a = 0; a < 256; a++) wr(c, a, a);
    cfg_swap = 1'b1; tick(); cfg_swap = 1'b0;
    chk("pend_set", 32'(cfg_swap_pend), 1);
    enable = 1'b0;
    send(24'($urandom), 1'b0, 1'b0);
    send(24'($urandom), 1'b0, 1'b0);
    chk("inflight_valid", 32'(m_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_m_valid", 32'(m_valid), 0);
    chk("rstmid_bank", 32'(active_bank), 0);
    chk("rstmid_pend", 32'(cfg_swap_pend), 0);
    repeat (2) tick();
    rst_n = 1'b1; enable = 1'b1;
    tick();

    // Frame A: swap to retained identity bank, full rate, fixed latency.
    cfg_swap = 1'b1; tick(); cfg_swap = 1'b0;
    strict = 1'b1;
    for (int i = 0; i < 256; i++) send({8'(i), 8'(i), 8'(i)}, i == 0, 1'b0);
    strict = 1'b0;
    drain();
    chk("frameA_bank", 32'(active_bank), 1);
    chk("frameA_pend", 32'(cfg_swap_pend), 0);

    // Bank 0: gamma on ch0, identity on ch1/ch2; swap requested mid-frame B, applies at frame C.
    for (int a = 0; a < 256; a++) begin
      wr(0, a, gamma8(a)); wr(1, a, a); wr(2, a, a);
    end
    for (int i = 0; i < 256; i++) send(24'($urandom), i == 0, i == 100);
    chk("frameB_bank", 32'(active_bank), 1);
    pin_gamma = 1'b1;
    for (int i = 0; i < 256; i++) send({16'($urandom), 8'(i)}, i == 0, 1'b0);
    drain();
    chk("frameC_bank", 32'(active_bank), 0);
    chk("frameC_pend", 32'(cfg_swap_pend), 0);

    // Pass-through widening, then per-beat enable changes.
    enable = 1'b0;
    repeat (4) send({8'd200, 8'd200, 8'd200}, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      enable = i[0];
      send({8'd128, 8'd128, 8'd128}, 1'b0, 1'b0);
    end
    pin_gamma = 1'b0;
    enable = 1'b1;
    drain();

    // Random backpressure, gaps, enable toggles, frame starts and swap requests.
    rand_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) tick();
      if ($urandom_range(0, 7) == 0) enable = ~enable;
      send(24'($urandom), $urandom_range(0, 63) == 0, $urandom_range(0, 49) == 0);
    end
    rand_ready = 1'b0;
    enable = 1'b1;
    drain();

`ifdef GAMMA_READBACK_EN
    wr(2, 17, 99);
    strict = 1'b1;
    fork
      begin
        for (int i = 0; i < 12; i++) send(24'($urandom), 1'b0, 1'b0);
      end
      begin
        tick();
        cfg_re = 1'b1; cfg_ch = 2'd2; cfg_addr = 8'd17;
        tick();
        cfg_re = 1'b0;
        chk("rb_rvalid_early", 32'(cfg_rvalid), 0);
        tick();
        chk("rb_rvalid", 32'(cfg_rvalid), 1);
        chk("rb_rdata", 32'(cfg_rdata), 99);
      end
    join
    strict = 1'b0;
    drain();
`else
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
